// File: rtl/pipe_skid_stage.sv
// Two-entry pipeline skid stage with flush and saturating statistics.
// The main entry drives the outputs. The skid entry catches one extra
// entry because in_ready is registered and so lags out_ready by a cycle.
//
// state | meaning
// EMPTY | no entry held; outputs zero
// ONE   | main valid; skid empty
// FULL  | main and skid valid; in_ready low
module pipe_skid_stage #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              Flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  drop_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   main_data, skid_data;
  logic [CTRL_W-1:0]   main_ctrl, skid_ctrl;
  logic                acc, ret;
  logic                load_main, load_skid, move_skid, clear_main;
  logic [1:0]          held_left, drop_inc;
  logic [CNT_W+1:0]    drop_sum;

  // Handshake flags come only from registered state, so out_ready never
  // reaches in_ready combinationally.
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign occupancy = 2'(state);
  assign acc       = in_valid & in_ready & ~Flush;
  assign ret       = out_valid & out_ready;
  assign out_data  = out_valid ? main_data : '0;
  assign out_ctrl  = out_valid ? main_ctrl : '0;

  // State register.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) state <= EMPTY;
    else       state <= state_nxt;
  end

  // Next state and datapath enables; Flush overrides every handshake.
  always_comb begin
    state_nxt  = state;
    load_main  = 1'b0;
    load_skid  = 1'b0;
    move_skid  = 1'b0;
    clear_main = 1'b0;
    if (Flush) begin
      state_nxt = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (acc) begin
            state_nxt = ONE;
            load_main = 1'b1;
          end
        end
        ONE: begin
          if (acc && ret) begin
            load_main = 1'b1;
          end else if (acc) begin
            state_nxt = FULL;
            load_skid = 1'b1;
          end else if (ret) begin
            state_nxt  = EMPTY;
            clear_main = 1'b1;
          end
        end
        FULL: begin
          if (ret) begin
            state_nxt = ONE;
            move_skid = 1'b1;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Entry storage; entries are zeroed whenever they stop being valid.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      main_data <= '0;
      main_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else if (Flush) begin
      main_data <= '0;
      main_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else begin
      if (load_main) begin
        main_data <= in_data;
        main_ctrl <= in_ctrl;
      end else if (move_skid) begin
        main_data <= skid_data;
        main_ctrl <= skid_ctrl;
      end else if (clear_main) begin
        main_data <= '0;
        main_ctrl <= '0;
      end
      if (load_skid) begin
        skid_data <= in_data;
        skid_ctrl <= in_ctrl;
      end else if (move_skid) begin
        skid_data <= '0;
        skid_ctrl <= '0;
      end
    end
  end

  // Drop amount on a flush edge: held entries not retiring plus an offered
  // entry that would otherwise have been accepted. At most 2.
  assign held_left = occupancy - {1'b0, ret};
  assign drop_inc  = held_left + {1'b0, in_valid & in_ready};
  assign drop_sum  = {2'b00, drop_cnt} + {{CNT_W{1'b0}}, drop_inc};

  // Saturating stall and drop counters.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      stall_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (out_valid && !out_ready && stall_cnt != CNT_MAX)
        stall_cnt <= stall_cnt + 1'b1;
      if (Flush) begin
        if (drop_sum > {2'b00, CNT_MAX}) drop_cnt <= CNT_MAX;
        else                             drop_cnt <= drop_sum[CNT_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Scoreboard bench for pipe_skid_stage: the driver pushes each accepted
// entry, a negedge monitor pops and compares on every retire.
module tb_pipe_skid_stage;

  logic        clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic [15:0] in_ctrl = '0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid;
  logic [31:0] out_data;
  logic [15:0] out_ctrl;
  logic [1:0]  occupancy;
  logic [7:0]  stall_cnt, drop_cnt;
  logic        in_ready2, out_valid2;
  logic [31:0] out_data2;
  logic [15:0] out_ctrl2;
  logic [1:0]  occupancy2;
  logic [1:0]  stall_cnt2, drop_cnt2;

  int n_cmp = 0;
  int n_err = 0;
  logic [47:0] sb[$];

  pipe_skid_stage dut (
    .clk(clk), .Reset(Reset), .Flush(Flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .occupancy(occupancy), .stall_cnt(stall_cnt), .drop_cnt(drop_cnt)
  );

  pipe_skid_stage #(.CNT_W(2)) dut2 (
    .clk(clk), .Reset(Reset), .Flush(Flush),
    .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2), .out_ctrl(out_ctrl2),
    .occupancy(occupancy2), .stall_cnt(stall_cnt2), .drop_cnt(drop_cnt2)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ctl(input logic [31:0] d);
    return d[15:0] ^ 16'h5A3C;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus, entered and left at posedge+1.
  task automatic cyc(input logic iv, input logic [31:0] d, input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = d;
    in_ctrl   = ctl(d);
    out_ready = ordy;
    Flush     = fl;
    if (iv && in_ready && !fl) sb.push_back({d, ctl(d)});
    @(posedge clk);
    #1;
    if (fl) sb.delete();
  endtask

  // Monitor: compare each retiring entry, and check zeroed outputs when idle.
  always @(negedge clk) begin
    logic [47:0] e;
    if (!Reset) begin
      if (out_valid) begin
        if (out_ready) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_output: got 0x%0h expected none", out_data);
          end else begin
            e = sb.pop_front();
            chk("out_data", {32'd0, out_data}, {32'd0, e[47:16]});
            chk("out_ctrl", {48'd0, out_ctrl}, {48'd0, e[15:0]});
          end
        end
      end else begin
        chk("idle_data", {32'd0, out_data}, 64'd0);
        chk("idle_ctrl", {48'd0, out_ctrl}, 64'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    #2 Reset = 1'b1;
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready",  {63'd0, in_ready}, 64'd1);
    chk("rst_occupancy", {62'd0, occupancy}, 64'd0);
    chk("rst_stall",     {56'd0, stall_cnt}, 64'd0);
    chk("rst_drop",      {56'd0, drop_cnt}, 64'd0);
    @(posedge clk); #1;
    Reset = 1'b0;

    // Single entry, one-cycle latency
    cyc(1, 32'h0040_0000, 1, 0);
    chk("lat_out_valid", {63'd0, out_valid}, 64'd1);
    chk("lat_occupancy", {62'd0, occupancy}, 64'd1);
    cyc(0, 32'h0, 1, 0);
    chk("lat_occ_back", {62'd0, occupancy}, 64'd0);

    // Backpressure: A, B accepted, C held upstream
    cyc(1, 32'hAAAA_0001, 0, 0);
    chk("bp_stall_a", {56'd0, stall_cnt}, 64'd0);
    cyc(1, 32'hBBBB_0002, 0, 0);
    chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
    chk("bp_occ_full", {62'd0, occupancy}, 64'd2);
    chk("bp_stall_b",  {56'd0, stall_cnt}, 64'd1);
    cyc(1, 32'hCCCC_0003, 0, 0);
    chk("bp_stall_c",  {56'd0, stall_cnt}, 64'd2);
    cyc(1, 32'hCCCC_0003, 1, 0);
    chk("bp_occ_one",  {62'd0, occupancy}, 64'd1);
    cyc(1, 32'hCCCC_0003, 1, 0);
    cyc(0, 32'h0, 1, 0);
    chk("bp_drained",  {62'd0, occupancy}, 64'd0);
    chk("bp_stall_end", {56'd0, stall_cnt}, 64'd2);

    // Flush: EMPTY with offer drops 1, then FULL with offer drops 2
    cyc(1, 32'h0BAD_0000, 0, 1);
    chk("fl_drop_empty", {56'd0, drop_cnt}, 64'd1);
    cyc(1, 32'hD000_0004, 0, 0);
    cyc(1, 32'hE000_0005, 0, 0);
    cyc(1, 32'hF000_0006, 0, 1);
    chk("fl_occupancy", {62'd0, occupancy}, 64'd0);
    chk("fl_out_valid", {63'd0, out_valid}, 64'd0);
    chk("fl_out_ctrl",  {48'd0, out_ctrl}, 64'd0);
    chk("fl_drop_full", {56'd0, drop_cnt}, 64'd3);
    chk("fl_stall",     {56'd0, stall_cnt}, 64'd4);
    // Flush in FULL with a concurrent retire: G delivered, H dropped
    cyc(1, 32'h6000_0007, 0, 0);
    cyc(1, 32'h7000_0008, 0, 0);
    cyc(1, 32'h8000_0009, 1, 1);
    chk("fl_drop_ret", {56'd0, drop_cnt}, 64'd4);
    cyc(0, 32'h0, 0, 0);

    // Asynchronous reset between edges while FULL
    cyc(1, 32'h1111_000A, 0, 0);
    cyc(1, 32'h2222_000B, 0, 0);
    chk("ar_occ_full", {62'd0, occupancy}, 64'd2);
    #2;
    in_valid = 1'b0;
    Reset = 1'b1;
    #1;
    chk("ar_out_valid", {63'd0, out_valid}, 64'd0);
    chk("ar_occupancy", {62'd0, occupancy}, 64'd0);
    chk("ar_in_ready",  {63'd0, in_ready}, 64'd1);
    chk("ar_drop",      {56'd0, drop_cnt}, 64'd0);
    chk("ar_stall",     {56'd0, stall_cnt}, 64'd0);
    chk("ar_out_data",  {32'd0, out_data}, 64'd0);
    chk("ar_out_ctrl",  {48'd0, out_ctrl}, 64'd0);
    sb.delete();
    @(posedge clk); #1;
    Reset = 1'b0;

    // Stall saturation on the CNT_W=2 instance
    cyc(1, 32'h3333_000C, 0, 0);
    for (int k = 1; k <= 6; k++) begin
      cyc(0, 32'h0, 0, 0);
      chk("sat_stall2", {62'd0, stall_cnt2}, (k < 3) ? 64'(k) : 64'd3);
    end
    chk("sat_stall8", {56'd0, stall_cnt}, 64'd6);
    // Drop saturation: two flushes in ONE with an offer, 2 each
    cyc(1, 32'h4444_000D, 0, 1);
    chk("sat_drop_a", {62'd0, drop_cnt2}, 64'd2);
    cyc(1, 32'h5555_000E, 0, 0);
    cyc(1, 32'h6666_000F, 0, 1);
    chk("sat_drop2",  {62'd0, drop_cnt2}, 64'd3);
    chk("sat_drop8",  {56'd0, drop_cnt}, 64'd4);
    chk("sat_stall_fl", {56'd0, stall_cnt}, 64'd8);
    chk("sat_stall2_hold", {62'd0, stall_cnt2}, 64'd3);
    cyc(0, 32'h0, 0, 0);

    // Streaming: 100 entries back to back
    #2 Reset = 1'b1;
    #1 Reset = 1'b0;
    sb.delete();
    for (int i = 0; i < 100; i++) begin
      cyc(1, 32'h0000_1000 + 32'(i), 1, 0);
      chk("st_out_valid", {63'd0, out_valid}, 64'd1);
      chk("st_data_delay", {32'd0, out_data}, {32'd0, 32'h0000_1000 + 32'(i)});
    end
    cyc(0, 32'h0, 1, 0);
    chk("st_stall", {56'd0, stall_cnt}, 64'd0);
    chk("st_occ_end", {62'd0, occupancy}, 64'd0);

    cyc(0, 32'h0, 0, 0);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
